exc_ctrl: RTL and testbench



---
 rtl/exc_ctrl_pkg.sv | 34 +++
 rtl/exc_ctrl_if.sv | 38 +++
 rtl/exc_ctrl_irq_sync.sv | 31 +++
 rtl/exc_ctrl.sv | 130 +++++++++++++
 tb/tb_exc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: ExcCode values,
// the general exception vector and the commit FSM state type.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SETTLE = 2'd2
    } exc_state_t;

    // Only memory-address faults carry a meaningful faulting address.
    function automatic logic exc_sets_badvaddr(input logic [4:0] code);
        logic hit;
        case (code)
            EXC_ADEL, EXC_ADES, EXC_MOD, EXC_TLBL, EXC_TLBS: hit = 1'b1;
            default:                                        hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// WB-stage exception bus: WB instruction attributes, flush/redirect
// handshake and the CP0 commit strobes.
interface exc_ctrl_if;

    logic        WB_Valid;
    logic        WB_ExcValid;
    logic [4:0]  WB_ExcCode;
    logic        WB_IsEret;
    logic [31:0] WB_PC;
    logic [31:0] WB_ALUOut;
    logic        WB_IsInDelaySlot;
    logic        Flush_Ack;

    logic        Flush_Req;
    logic [31:0] Redirect_PC;
    logic        WB_Kill;
    logic        Exc_We;
    logic [31:0] Exc_EPC;
    logic        Exc_BD;
    logic [4:0]  Exc_Code;
    logic        BadVAddr_We;
    logic        Eret_We;

    modport master (
        output WB_Valid, WB_ExcValid, WB_ExcCode, WB_IsEret, WB_PC,
               WB_ALUOut, WB_IsInDelaySlot, Flush_Ack,
        input  Flush_Req, Redirect_PC, WB_Kill, Exc_We, Exc_EPC, Exc_BD,
               Exc_Code, BadVAddr_We, Eret_We
    );

    modport slave (
        input  WB_Valid, WB_ExcValid, WB_ExcCode, WB_IsEret, WB_PC,
               WB_ALUOut, WB_IsInDelaySlot, Flush_Ack,
        output Flush_Req, Redirect_PC, WB_Kill, Exc_We, Exc_EPC, Exc_BD,
               Exc_Code, BadVAddr_We, Eret_We
    );

endinterface

// File: rtl/exc_ctrl_irq_sync.sv
// Multi-bit flop synchronizer for asynchronous interrupt lines, with a
// synchronous active-low clear.
module irq_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             clr_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift chain; each line is synchronized independently.
    always_ff @(posedge clk) begin
        if (!clr_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Precise-exception / interrupt controller between WB and CP0: arbitrates
// interrupts, WB exceptions and ERET, then runs the flush/redirect handshake.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = exc_ctrl_pkg::EXC_VECTOR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Interrupt,
    input  logic        TimerInt,
    input  logic        Status_IE,
    input  logic        Status_EXL,
    input  logic [7:0]  Status_IM,
    input  logic [1:0]  Cause_IP_sw,
    input  logic [31:0] CP0_EPC,
    output logic [5:0]  Cause_IP_hw,
    exc_ctrl_if.slave   bus
);

    import exc_ctrl_pkg::*;

    logic [5:0]  irq_sync_q;
    exc_state_t  state_q;
    logic        flush_req_q;
    logic [31:0] redirect_q;

    logic        in_idle;
    logic        int_pending;
    logic        commit_int;
    logic        commit_exc;
    logic        commit_eret;
    logic        exc_commit;

    irq_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_irq_sync (
        .clk     (clk),
        .clr_n_i (rst),
        .d_i     (Interrupt),
        .q_o     (irq_sync_q)
    );

    // Timer shares IP7 with HW5.
    assign Cause_IP_hw = {irq_sync_q[5] | TimerInt, irq_sync_q[4:0]};

    // Commit arbitration: interrupt > WB exception > ERET, only from IDLE.
    always_comb begin
        in_idle     = (state_q == IDLE);
        int_pending = Status_IE & ~Status_EXL &
                      (|({Cause_IP_hw, Cause_IP_sw} & Status_IM));
        commit_int  = 1'b0;
        commit_exc  = 1'b0;
        commit_eret = 1'b0;
        if (rst && in_idle && bus.WB_Valid) begin
            if (int_pending) begin
                commit_int = 1'b1;
            end else if (bus.WB_ExcValid) begin
                commit_exc = 1'b1;
            end else begin
                commit_eret = bus.WB_IsEret;
            end
        end else begin
            commit_int = 1'b0;
        end
        exc_commit = commit_int | commit_exc;
    end

    // CP0 strobes are combinational in the commit cycle; data fields are
    // forced to zero whenever no exception is being written.
    always_comb begin
        bus.Exc_We      = exc_commit;
        bus.Eret_We     = commit_eret;
        bus.BadVAddr_We = commit_exc & exc_sets_badvaddr(bus.WB_ExcCode);
        bus.WB_Kill     = rst & bus.WB_Valid &
                          (~in_idle | exc_commit | commit_eret);
        if (exc_commit) begin
            bus.Exc_BD   = bus.WB_IsInDelaySlot;
            bus.Exc_EPC  = bus.WB_IsInDelaySlot ? (bus.WB_PC - 32'd4) : bus.WB_PC;
            bus.Exc_Code = commit_int ? EXC_INT : bus.WB_ExcCode;
        end else begin
            bus.Exc_BD   = 1'b0;
            bus.Exc_EPC  = 32'd0;
            bus.Exc_Code = 5'd0;
        end
    end

    assign bus.Flush_Req   = flush_req_q;
    assign bus.Redirect_PC = redirect_q;

    // Commit FSM: IDLE -> FLUSH (until Flush_Ack) -> SETTLE (one cycle) -> IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            flush_req_q <= 1'b0;
            redirect_q  <= EXC_VECTOR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exc_commit || commit_eret) begin
                        state_q     <= FLUSH;
                        flush_req_q <= 1'b1;
                        redirect_q  <= commit_eret ? CP0_EPC : EXC_VECTOR;
                    end else begin
                        state_q     <= IDLE;
                        flush_req_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (bus.Flush_Ack) begin
                        state_q     <= SETTLE;
                        flush_req_q <= 1'b0;
                    end else begin
                        state_q     <= FLUSH;
                        flush_req_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    state_q     <= IDLE;
                    flush_req_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    flush_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized self-checking bench for exc_ctrl against a behavioural model
// of the commit rules, preceded by directed scenarios.
module tb_exc_ctrl;

    localparam logic [31:0] VEC  = 32'hBFC0_0380;
    localparam int          SYNC = 2;

    logic        clk;
    logic        rst;
    logic [5:0]  Interrupt;
    logic        TimerInt;
    logic        Status_IE;
    logic        Status_EXL;
    logic [7:0]  Status_IM;
    logic [1:0]  Cause_IP_sw;
    logic [31:0] CP0_EPC;
    logic [5:0]  Cause_IP_hw;

    exc_ctrl_if bus();

    exc_ctrl #(
        .EXC_VECTOR  (VEC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Interrupt   (Interrupt),
        .TimerInt    (TimerInt),
        .Status_IE   (Status_IE),
        .Status_EXL  (Status_EXL),
        .Status_IM   (Status_IM),
        .Cause_IP_sw (Cause_IP_sw),
        .CP0_EPC     (CP0_EPC),
        .Cause_IP_hw (Cause_IP_hw),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: interrupt line history (newest first), handshake phase and target.
    logic [5:0]  irq_hist [$];
    int          m_phase;      // 0 free, 1 awaiting ack, 2 settling
    logic [31:0] m_redirect;
    int          m_kind;       // 0 none, 1 interrupt, 2 exception, 3 eret
    logic [31:0] m_target;

    logic [4:0] codes [8] = '{5'h04, 5'h05, 5'h01, 5'h02, 5'h03, 5'h08, 5'h0c, 5'h0a};

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic eval();
        logic [5:0] e_hw;
        logic [5:0] e_ip;
        logic       pend;
        logic       e_exc;
        @(negedge clk);
        e_hw = irq_hist[SYNC-1];
        e_ip = {e_hw[5] | TimerInt, e_hw[4:0]};
        pend = Status_IE && !Status_EXL && ((({e_ip, Cause_IP_sw}) & Status_IM) != 8'd0);
        m_kind = 0;
        if (rst && m_phase == 0 && bus.WB_Valid) begin
            if (pend)                 m_kind = 1;
            else if (bus.WB_ExcValid) m_kind = 2;
            else if (bus.WB_IsEret)   m_kind = 3;
        end
        m_target = (m_kind == 3) ? CP0_EPC : VEC;
        e_exc = (m_kind == 1 || m_kind == 2);
        check_eq("ip_hw", {26'd0, Cause_IP_hw}, {26'd0, e_ip});
        check_eq("exc_we", {31'd0, bus.Exc_We}, {31'd0, e_exc});
        check_eq("eret_we", {31'd0, bus.Eret_We}, {31'd0, m_kind == 3});
        check_eq("badva_we", {31'd0, bus.BadVAddr_We},
                 {31'd0, m_kind == 2 && (bus.WB_ExcCode inside {5'h01, 5'h02, 5'h03, 5'h04, 5'h05})});
        check_eq("wb_kill", {31'd0, bus.WB_Kill},
                 {31'd0, rst && bus.WB_Valid && (m_kind != 0 || m_phase != 0)});
        check_eq("flush_req", {31'd0, bus.Flush_Req}, {31'd0, m_phase == 1});
        check_eq("redirect", bus.Redirect_PC, m_redirect);
        if (e_exc) begin
            check_eq("exc_code", {27'd0, bus.Exc_Code},
                     {27'd0, (m_kind == 1) ? 5'h00 : bus.WB_ExcCode});
            check_eq("exc_epc", bus.Exc_EPC,
                     bus.WB_IsInDelaySlot ? bus.WB_PC - 32'd4 : bus.WB_PC);
            check_eq("exc_bd", {31'd0, bus.Exc_BD}, {31'd0, bus.WB_IsInDelaySlot});
        end
    endtask

    task automatic tick();
        if (!rst) begin
            m_phase    = 0;
            m_redirect = VEC;
            irq_hist.delete();
            for (int i = 0; i < SYNC; i++) irq_hist.push_back(6'd0);
        end else begin
            irq_hist.push_front(Interrupt);
            void'(irq_hist.pop_back());
            case (m_phase)
                0: if (m_kind != 0) begin m_phase = 1; m_redirect = m_target; end
                1: if (bus.Flush_Ack) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        eval();
        tick();
    endtask

    task automatic clear_wb();
        bus.WB_Valid = 1'b0; bus.WB_ExcValid = 1'b0; bus.WB_ExcCode = 5'd0;
        bus.WB_IsEret = 1'b0; bus.WB_IsInDelaySlot = 1'b0;
        bus.WB_PC = 32'd0; bus.WB_ALUOut = 32'd0;
    endtask

    task automatic finish_flush();
        clear_wb();
        bus.Flush_Ack = 1'b1;
        cyc();
        bus.Flush_Ack = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b0; Interrupt = 6'd0; TimerInt = 1'b0; Status_IE = 1'b0;
        Status_EXL = 1'b0; Status_IM = 8'd0; Cause_IP_sw = 2'd0; CP0_EPC = 32'd0;
        clear_wb();
        bus.Flush_Ack = 1'b0;
        m_phase = 0; m_redirect = VEC; m_kind = 0; m_target = VEC;
        tick();
        tick();
        eval();
        check_eq("rst_redirect", bus.Redirect_PC, VEC);
        tick();
        rst = 1'b1;
        cyc();

        // Address fault.
        bus.WB_Valid = 1'b1; bus.WB_ExcValid = 1'b1; bus.WB_ExcCode = 5'h04;
        bus.WB_PC = 32'h8000_1000; bus.WB_ALUOut = 32'h0000_1233;
        eval();
        check_eq("ad_we", {31'd0, bus.Exc_We}, 32'd1);
        check_eq("ad_epc", bus.Exc_EPC, 32'h8000_1000);
        check_eq("ad_bd", {31'd0, bus.Exc_BD}, 32'd0);
        check_eq("ad_bva", {31'd0, bus.BadVAddr_We}, 32'd1);
        check_eq("ad_kill", {31'd0, bus.WB_Kill}, 32'd1);
        tick();
        clear_wb();
        eval();
        check_eq("ad_flush", {31'd0, bus.Flush_Req}, 32'd1);
        check_eq("ad_redir", bus.Redirect_PC, 32'hBFC0_0380);
        bus.Flush_Ack = 1'b1;
        tick();
        bus.Flush_Ack = 1'b0;
        cyc();

        // Syscall in a delay slot; ack arrives with Flush_Req's rise.
        bus.WB_Valid = 1'b1; bus.WB_ExcValid = 1'b1; bus.WB_ExcCode = 5'h08;
        bus.WB_IsInDelaySlot = 1'b1; bus.WB_PC = 32'h8000_0004;
        eval();
        check_eq("ds_epc", bus.Exc_EPC, 32'h8000_0000);
        check_eq("ds_bd", {31'd0, bus.Exc_BD}, 32'd1);
        check_eq("ds_bva", {31'd0, bus.BadVAddr_We}, 32'd0);
        tick();
        finish_flush();

        // Interrupt pulse on HW2 beats a simultaneous overflow.
        Status_IE = 1'b1; Status_EXL = 1'b0; Status_IM = 8'h10;
        Interrupt = 6'b000100;
        cyc();
        Interrupt = 6'd0;
        cyc();
        bus.WB_Valid = 1'b1; bus.WB_ExcValid = 1'b1; bus.WB_ExcCode = 5'h0c;
        bus.WB_PC = 32'h8000_0100;
        eval();
        check_eq("irq_we", {31'd0, bus.Exc_We}, 32'd1);
        check_eq("irq_code", {27'd0, bus.Exc_Code}, 32'd0);
        check_eq("irq_bva", {31'd0, bus.BadVAddr_We}, 32'd0);
        tick();
        finish_flush();

        // Same interrupt masked by EXL, then taken once EXL clears.
        Status_EXL = 1'b1; Interrupt = 6'b000100;
        bus.WB_Valid = 1'b1; bus.WB_PC = 32'h8000_0200;
        for (int i = 0; i < 4; i++) begin
            eval();
            check_eq("mask_we", {31'd0, bus.Exc_We}, 32'd0);
            tick();
        end
        Status_EXL = 1'b0; bus.WB_Valid = 1'b0;
        cyc();
        bus.WB_Valid = 1'b1;
        eval();
        check_eq("unmask_we", {31'd0, bus.Exc_We}, 32'd1);
        check_eq("unmask_code", {27'd0, bus.Exc_Code}, 32'd0);
        tick();
        finish_flush();
        Interrupt = 6'd0; Status_IE = 1'b0;
        cyc(); cyc();

        // ERET, with a WB exception arriving during FLUSH and SETTLE.
        CP0_EPC = 32'h8000_2000;
        bus.WB_Valid = 1'b1; bus.WB_IsEret = 1'b1;
        eval();
        check_eq("eret_we1", {31'd0, bus.Eret_We}, 32'd1);
        check_eq("eret_exc", {31'd0, bus.Exc_We}, 32'd0);
        tick();
        bus.WB_IsEret = 1'b0; bus.WB_ExcValid = 1'b1; bus.WB_ExcCode = 5'h04;
        eval();
        check_eq("eret_redir", bus.Redirect_PC, 32'h8000_2000);
        check_eq("fl_kill", {31'd0, bus.WB_Kill}, 32'd1);
        check_eq("fl_noexc", {31'd0, bus.Exc_We}, 32'd0);
        bus.Flush_Ack = 1'b1;
        tick();
        bus.Flush_Ack = 1'b0;
        eval();
        check_eq("st_kill", {31'd0, bus.WB_Kill}, 32'd1);
        check_eq("st_noexc", {31'd0, bus.Exc_We}, 32'd0);
        tick();
        clear_wb();
        cyc();

        // Stalled handshake interrupted by reset in its third cycle.
        bus.WB_Valid = 1'b1; bus.WB_ExcValid = 1'b1; bus.WB_ExcCode = 5'h0a;
        cyc();
        clear_wb();
        for (int i = 0; i < 2; i++) begin
            eval();
            check_eq("hold_flush", {31'd0, bus.Flush_Req}, 32'd1);
            tick();
        end
        rst = 1'b0;
        bus.WB_Valid = 1'b1; bus.WB_ExcValid = 1'b1; bus.WB_ExcCode = 5'h04;
        eval();
        check_eq("rst_we", {31'd0, bus.Exc_We}, 32'd0);
        check_eq("rst_kill", {31'd0, bus.WB_Kill}, 32'd0);
        tick();
        rst = 1'b1;
        clear_wb();
        eval();
        check_eq("rst_flush", {31'd0, bus.Flush_Req}, 32'd0);
        tick();
        cyc(); cyc();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rst                  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 7) == 0) Interrupt = 6'($urandom);
            if ($urandom_range(0, 9) == 0) TimerInt = ~TimerInt;
            Status_IE            = ($urandom_range(0, 2) != 0);
            Status_EXL           = ($urandom_range(0, 3) == 0);
            Status_IM            = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            Cause_IP_sw          = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'd0;
            CP0_EPC              = $urandom;
            bus.WB_Valid         = ($urandom_range(0, 3) != 0);
            bus.WB_ExcValid      = ($urandom_range(0, 3) == 0);
            bus.WB_ExcCode       = codes[$urandom_range(0, 7)];
            bus.WB_IsEret        = ($urandom_range(0, 5) == 0);
            bus.WB_PC            = $urandom;
            bus.WB_ALUOut        = $urandom;
            bus.WB_IsInDelaySlot = $urandom_range(0, 1) != 0;
            bus.Flush_Ack        = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
